// File: rtl/rr_or_arbiter.sv
// rr_or_arbiter: round-robin arbiter; one owner of a shared resource among N requesters, request detect is an OR reduction.
// Latency: grant registered 1 cycle after req sampled in IDLE; at least one idle cycle (gnt_valid=0) between grants.
// Backpressure: requesters hold req until served; owner frees the grant with a rel pulse or by dropping its req.
// Optional: define ARB_TIMEOUT_EN to force a release after HOLD_MAX grant cycles and pulse tout.
module rr_or_arbiter #(
  parameter int N        = 4,
  parameter int IW       = $clog2(N),
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          rel,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_valid,
  output logic          any_req
`ifdef ARB_TIMEOUT_EN
  ,
  output logic          tout
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [N-1:0]  hi_req;
  logic [IW-1:0] sel_id;
  logic          owner_req;
  logic          release_now;
  logic          hold_expired;
  logic [IW-1:0] ptr_next;

  assign any_req = |req;

  // gnt is one-hot, so masking req with it yields the owner's own request line
  assign owner_req   = |(req & gnt);
  assign release_now = rel | ~owner_req;

  // After a hand-over, priority starts just past the previous owner
  assign ptr_next = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] hold_cnt;
  // Counter holds completed grant cycles; the current cycle is the HOLD_MAX-th when it reads HOLD_MAX-1
  assign hold_expired = (hold_cnt == CW'(HOLD_MAX - 1));
`else
  assign hold_expired = 1'b0;
`endif

  // Requests at or above the priority pointer win over those that wrapped below it
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req[i] && (IW'(i) >= ptr);
    end
  end

  // Lowest-index winner in the upper band, otherwise lowest-index winner overall (wrap)
  always_comb begin
    sel_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi_req != '0) begin
        if (hi_req[i]) sel_id = IW'(i);
      end else if (req[i]) begin
        sel_id = IW'(i);
      end
    end
  end

  // Arbitration FSM with registered grant outputs, pointer and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      tout      <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // rel carries no meaning without an owner
          if (any_req) begin
            gnt       <= {{(N-1){1'b0}}, 1'b1} << sel_id;
            gnt_id    <= sel_id;
            gnt_valid <= 1'b1;
            state     <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now || hold_expired) begin
            // gnt_id keeps the last owner for downstream bookkeeping
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= ptr_next;
            state     <= IDLE;
`ifdef ARB_TIMEOUT_EN
            tout      <= ~release_now;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_or_arbiter.sv
// tb_rr_or_arbiter: scoreboard bench for rr_or_arbiter against a distance-based round-robin model.
// Latency: expectations are tagged with the cycle they become visible and checked on the falling edge.
// Backpressure: none; stimulus is driven every cycle, directed scenarios first, then random traffic.
`timescale 1ns/1ps
module tb_rr_or_arbiter;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int HOLD_MAX = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req   = '0;
  logic          rel   = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          any_req;
`ifdef ARB_TIMEOUT_EN
  logic          tout;
`endif

  rr_or_arbiter #(.N(N), .IW(IW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .any_req   (any_req)
`ifdef ARB_TIMEOUT_EN
    ,
    .tout      (tout)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [N-1:0]  gnt;
    logic [IW-1:0] id;
    logic          vld;
    logic          to;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: who owns the resource, where priority starts, last owner index
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push_exp(input int due, input logic to);
    exp_t e;
    e.due = due;
    e.gnt = '0;
    if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
    e.id  = IW'(m_last);
    e.vld = (m_owner >= 0);
    e.to  = to;
    q.push_back(e);
  endtask

  // One clock of arbitration: winner is the requester at smallest forward distance from ptr
  task automatic model_step(input logic [N-1:0] r, input logic l);
    int   best;
    int   bestd;
    logic to;
    to = 1'b0;
    if (m_owner < 0) begin
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        if (r[i] && ((i - m_ptr + N) % N) < bestd) begin
          bestd = (i - m_ptr + N) % N;
          best  = i;
        end
      end
      if (best >= 0) begin
        m_owner = best;
        m_last  = best;
        m_hold  = 0;
      end
    end else if (l || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      m_hold++;
      if (m_hold == HOLD_MAX) begin
        to      = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
`endif
    end
    push_exp(cyc + 1, to);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic l);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req   = r;
    rel   = l;
    model_step(r, l);
    #1;
    check("any_req", 32'(any_req), 32'(|r));
  endtask

  // Assert reset away from the clock edge and confirm outputs clear without waiting for a clock
  task automatic apply_reset(input logic [N-1:0] r, input int ncyc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = r;
    rel   = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    q.delete();
    push_exp(cyc, 1'b0);
    push_exp(cyc + 1, 1'b0);
    #1;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_gnt_valid", 32'(gnt_valid), 32'(0));
    check("rst_gnt_id", 32'(gnt_id), 32'(0));
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk);
      #2;
      push_exp(cyc + 1, 1'b0);
    end
  endtask

  // Monitor: every falling edge, compare the outputs the scoreboard says are due now
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("gnt_id", 32'(gnt_id), 32'(e.id));
        check("gnt_valid", 32'(gnt_valid), 32'(e.vld));
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
`ifdef ARB_TIMEOUT_EN
        check("tout", 32'(tout), 32'(e.to));
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    logic         l;
    #1 rst_n = 1'b0;

    // Reset with all requesting, then first grant goes to requester 0
    apply_reset(4'b1111, 3);
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b0);

    // Single requester 2; after release ptr=3 so requester 3 wins over 0
    apply_reset(4'b0000, 2);
    drive(4'b0100, 1'b1);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    drive(4'b0000, 1'b0);
    drive(4'b1001, 1'b0);
    drive(4'b1001, 1'b1);
    drive(4'b0000, 1'b0);

    // Rotation and wrap with rel pulsed on every grant
    apply_reset(4'b0000, 2);
    for (int k = 0; k < 14; k++) drive(4'b1111, m_owner >= 0);

    // Release by dropping req, then ptr=2 wraps to requester 0
    apply_reset(4'b0000, 2);
    drive(4'b0010, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b1);
    drive(4'b0011, 1'b0);

    // Reset mid-grant aborts the grant and restarts priority at 0
    apply_reset(4'b0000, 2);
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    apply_reset(4'b1000, 1);
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Requester 0 never releases; timeout hands over to requester 1
    apply_reset(4'b0000, 2);
    for (int k = 0; k < 14; k++) drive(4'b0011, 1'b0);
`endif

    // Random traffic: sticky requests, random rel (also in idle), occasional drops and resets
    apply_reset(4'b0000, 2);
    cur = '0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 700 == 699) begin
        apply_reset(4'($urandom_range(15)), 1 + $urandom_range(2));
        cur = '0;
      end
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) cur[i] = 1'b1;
      if (m_owner >= 0 && $urandom_range(7) == 0) cur[m_owner] = 1'b0;
      if (m_owner < 0 && $urandom_range(1) == 0) cur[m_last] = 1'b0;
      l = ($urandom_range(4) == 0);
      drive(cur, l);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
